data_cache_sa: RTL and testbench

- Parametrised N-way set-associative, write-through, no-write-allocate data cache between the pipeline memory stage and main data memory.
- Block size is one 32-bit word. Supports byte (lbu/sb) and word (lw/sw) accesses.
- Adds three capabilities over the current fixed 2-way lbu/sb cache:
  - miss handling with a req/ack memory handshake;
  - a pipeline stall output;
  - a real reset.

---
 rtl/cache_pkg.sv | 47 ++++
 rtl/cache_plru.sv | 39 +++
 rtl/data_cache_sa.sv | 236 +++++++++++++++++++++++
 tb/tb_data_cache_sa.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache:
// FSM state encoding, access-size codes, store lane helpers and the
// pseudo-LRU tree update/victim functions (2-way and 4-way).
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  // Byte enables for a store: all lanes for a word, one lane for a byte.
  function automatic logic [3:0] lane_be(input logic size, input logic [1:0] off);
    return (size == SZ_WORD) ? 4'b1111 : (4'b0001 << off);
  endfunction

  // Store data as seen on the bus: a byte is replicated into every lane.
  function automatic logic [31:0] lane_rep(input logic size, input logic [31:0] wd);
    return (size == SZ_WORD) ? wd : {4{wd[7:0]}};
  endfunction

  // Tree bits point at the half holding the next victim. For 2 ways only
  // bit 0 is used and it names the way that was not most recently used.
  function automatic logic [2:0] plru_touch(input int ways, input logic [2:0] st,
                                            input logic [1:0] way);
    logic [2:0] n;
    n = st;
    if (ways == 2) begin
      n[0] = ~way[0];
    end else begin
      n[0] = ~way[1];
      if (!way[1]) n[1] = ~way[0];
      else         n[2] = ~way[0];
    end
    return n;
  endfunction

  function automatic logic [1:0] plru_victim(input int ways, input logic [2:0] st);
    if (ways == 2) return {1'b0, st[0]};
    return st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set pseudo-LRU replacement state. One touch port updates the tree of
// the touched set; the victim port reports the PLRU choice for a set.
module cache_plru
  import cache_pkg::*;
#(
  parameter int SET_BITS = 3,
  parameter int WAYS     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                touch_en,
  input  logic [SET_BITS-1:0] touch_set,
  input  logic [1:0]          touch_way,
  input  logic [SET_BITS-1:0] victim_set,
  output logic [1:0]          victim_way
);

  localparam int SETS = 1 << SET_BITS;

  logic [2:0] plru_st [SETS];

  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    logic [2:0] st_q;

    // Each set's tree only moves when that set is touched.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q <= '0;
      end else if (touch_en && (touch_set == SET_BITS'(gi))) begin
        st_q <= plru_touch(WAYS, st_q, touch_way);
      end
    end

    assign plru_st[gi] = st_q;
  end

  assign victim_way = plru_victim(WAYS, plru_st[victim_set]);

endmodule

// File: rtl/data_cache_sa.sv
// N-way set-associative, write-through, no-write-allocate data cache with
// one-word lines. Loads hit in zero cycles; load misses fetch the word over
// a req/ack handshake and then re-look-up; every store is written through
// and retires in a one-cycle RESP state.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss/write counters.
module data_cache_sa
  import cache_pkg::*;
#(
  parameter int SET_BITS   = 3,
  parameter int WAYS       = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  we,
  input  logic                  size,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_writes
`endif
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 30 - SET_BITS;

  if (WAYS != 2 && WAYS != 4) begin : g_bad_ways
    $error("data_cache_sa: WAYS must be 2 or 4");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_cache_sa: DATA_WIDTH must be 32");
  end

  state_e state_q, state_d;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag_in;
  logic [1:0]          off;

  assign set_idx = addr[SET_BITS+1:2];
  assign tag_in  = addr[31:SET_BITS+2];
  assign off     = addr[1:0];

  logic [WAYS-1:0] way_hit;
  logic [WAYS-1:0] way_valid;
  logic [31:0]     way_data [WAYS];

  logic        any_hit, any_inv;
  logic [1:0]  hit_way, inv_way, plru_way, fill_way, touch_way;
  logic [31:0] hit_data;
  logic        fill_en, merge_en, touch_en, stall_c;
  logic [3:0]  be_c;
  logic [31:0] rep_c, be_mask, merged;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];
    logic             fill_this, merge_this;

    assign fill_this  = fill_en && (fill_way == 2'(gi));
    assign merge_this = merge_en && (hit_way == 2'(gi));

    assign way_valid[gi] = valid_q[set_idx];
    assign way_hit[gi]   = valid_q[set_idx] && (tag_q[set_idx] == tag_in);
    assign way_data[gi]  = data_q[set_idx];

    // Valid bits are the only per-line state that reset has to clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
      end else if (fill_this) begin
        valid_q[set_idx] <= 1'b1;
      end
    end

    // Tag/data payload: written by a miss fill or a store-hit merge.
    always_ff @(posedge clk) begin
      if (fill_this) begin
        tag_q[set_idx]  <= tag_in;
        data_q[set_idx] <= mem_rdata;
      end else if (merge_this) begin
        data_q[set_idx] <= merged;
      end
    end
  end

  // Pick the hitting way and the lowest-index invalid way in the set.
  always_comb begin
    any_hit  = |way_hit;
    any_inv  = ~&way_valid;
    hit_way  = '0;
    hit_data = '0;
    inv_way  = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) begin
        hit_way  = 2'(i);
        hit_data = way_data[i];
      end
      if (!way_valid[i]) inv_way = 2'(i);
    end
  end

  assign fill_way = any_inv ? inv_way : plru_way;

  assign hit   = req_valid & any_hit;
  assign rdata = (hit && !we)
               ? ((size == SZ_WORD) ? hit_data : {24'b0, hit_data[{off, 3'b000} +: 8]})
               : '0;

  assign be_c    = lane_be(size, off);
  assign rep_c   = lane_rep(size, wdata);
  assign be_mask = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
  assign merged  = (hit_data & ~be_mask) | (rep_c & be_mask);

  // Controller: next state, memory bus outputs and array write strobes.
  always_comb begin
    state_d   = state_q;
    stall_c   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    fill_en   = 1'b0;
    merge_en  = 1'b0;
    touch_en  = 1'b0;
    touch_way = hit_way;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (we) begin
            stall_c = 1'b1;
            state_d = WR_THRU;
          end else if (any_hit) begin
            touch_en = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        mem_req  = 1'b1;
        mem_addr = {addr[31:2], 2'b00};
        stall_c  = 1'b1;
        if (mem_ack) begin
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_way = fill_way;
          state_d   = IDLE;
        end
      end
      WR_THRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[31:2], 2'b00};
        mem_wdata = rep_c;
        mem_be    = be_c;
        stall_c   = 1'b1;
        if (mem_ack) begin
          merge_en = any_hit;
          touch_en = any_hit;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must release the pipeline at once, even with a miss still presented.
  assign stall = stall_c & ~rst;

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  cache_plru #(
    .SET_BITS(SET_BITS),
    .WAYS    (WAYS)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .touch_en  (touch_en),
    .touch_set (set_idx),
    .touch_way (touch_way),
    .victim_set(set_idx),
    .victim_way(plru_way)
  );

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q, writes_q;
  logic        hit_ev, miss_ev, write_ev;

  assign hit_ev   = (state_q == IDLE) && req_valid && !we && any_hit;
  assign miss_ev  = (state_q == IDLE) && (state_d == RD_MISS);
  assign write_ev = (state_q == WR_THRU) && mem_ack;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      writes_q <= '0;
    end else begin
      if (hit_ev && hits_q != '1)     hits_q   <= hits_q + 32'd1;
      if (miss_ev && misses_q != '1)  misses_q <= misses_q + 32'd1;
      if (write_ev && writes_q != '1) writes_q <= writes_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_writes = writes_q;
`endif

endmodule

// File: tb/tb_data_cache_sa.sv
// Self-checking bench for data_cache_sa (SET_BITS=3, WAYS=2). The bench plays
// main memory and keeps a reference model: per set, two line slots holding a
// word address and data plus the most recently used slot (2-way LRU).
module tb_data_cache_sa;

  logic        clk, rst, req_valid, we, size;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        hit, stall, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writes;
`endif

  data_cache_sa #(.SET_BITS(3), .WAYS(2), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .we(we), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writes(stat_writes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mem_m [logic [31:0]];
  logic        m_valid [8][2];
  logic [31:0] m_addr  [8][2];
  logic [31:0] m_data  [8][2];
  int          m_mru   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return (wa * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] word, input logic sz,
                                         input logic [31:0] a);
    if (sz) return word;
    return (word >> (8 * int'(a[1:0]))) & 32'hFF;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [3:0] be,
                                        input logic [31:0] rep);
    logic [31:0] r;
    r = word;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = rep[8*b +: 8];
    return r;
  endfunction

  function automatic int m_find(input logic [31:0] wa);
    int s;
    s = int'(wa[4:2]);
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_addr[s][w] == wa) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < 2; w++) if (!m_valid[s][w]) return w;
    return 1 - m_mru[s];
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 8; s++) begin
      m_mru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_addr[s][w]  = '0;
        m_data[s][w]  = '0;
      end
    end
  endtask

  // One complete pipeline access, from presentation until the pipeline is released.
  task automatic access(input logic w, input logic sz, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, output logic was_hit,
                        output logic [31:0] rd_obs, output int stall_cyc);
    logic [31:0] wa, rep;
    logic [3:0]  be;
    int          s, way, v;
    wa  = {a[31:2], 2'b00};
    s   = int'(a[4:2]);
    way = m_find(wa);
    be  = sz ? 4'hF : (4'b0001 << a[1:0]);
    rep = sz ? wd : {4{wd[7:0]}};
    @(negedge clk);
    req_valid = 1'b1; we = w; size = sz; addr = a; wdata = wd; mem_ack = 1'b0;
    #1;
    was_hit   = hit;
    rd_obs    = rdata;
    stall_cyc = (stall === 1'b1) ? 1 : 0;
    check("lookup_hit", 32'(hit), 32'(way >= 0));
    if (!w && way >= 0) begin
      check("hit_stall", 32'(stall), 32'd0);
      check("hit_rdata", rdata, ld_val(m_data[s][way], sz, a));
      m_mru[s] = way;
    end else begin
      check("busy0_stall", 32'(stall), 32'd1);
      check("busy0_rdata", rdata, 32'd0);
      for (int c = 0; c <= dly; c++) begin
        @(negedge clk);
        mem_ack   = (c == dly);
        mem_rdata = mem_rd(wa);
        #1;
        check("mem_req", 32'(mem_req), 32'd1);
        check("mem_we", 32'(mem_we), 32'(w));
        check("mem_addr", mem_addr, wa);
        check("busy_stall", 32'(stall), 32'd1);
        if (w) begin
          check("mem_be", 32'(mem_be), 32'(be));
          check("mem_wdata", mem_wdata, rep);
        end
        if (stall === 1'b1) stall_cyc++;
      end
      if (!w) begin
        v = m_victim(s);
        m_valid[s][v] = 1'b1;
        m_addr[s][v]  = wa;
        m_data[s][v]  = mem_rd(wa);
        m_mru[s]      = v;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("refill_hit", 32'(hit), 32'd1);
        check("refill_stall", 32'(stall), 32'd0);
        check("refill_rdata", rdata, ld_val(m_data[s][v], sz, a));
        rd_obs = rdata;
      end else begin
        mem_m[wa] = merge(mem_rd(wa), be, rep);
        if (way >= 0) begin
          m_data[s][way] = merge(m_data[s][way], be, rep);
          m_mru[s]       = way;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("resp_stall", 32'(stall), 32'd0);
        check("resp_mem_req", 32'(mem_req), 32'd0);
      end
    end
  endtask

  task automatic idle(input logic ack);
    @(negedge clk);
    req_valid = 1'b0; we = 1'b0; mem_ack = ack;
    #1;
    check("idle_hit", 32'(hit), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_mem_req", 32'(mem_req), 32'd0);
    check("idle_rdata", rdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic        h;
    logic [31:0] r, a;
    int          sc;

    m_clear();
    rst = 1'b1; req_valid = 1'b1; we = 1'b0; size = 1'b1; addr = 32'h100;
    wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;

    // Cold word load, memory answers after three waiting cycles.
    mem_m[32'h100] = 32'hDEADBEEF;
    access(1'b0, 1'b1, 32'h100, 32'h0, 3, h, r, sc);
    $display("lw  0x100 cold: hit=%0b rdata=%h stall_cycles=%0d", h, r, sc);
    check("cold_lw_first_hit", 32'(h), 32'd0);
    check("cold_lw_stall_cycles", 32'(sc), 32'd5);
    check("cold_lw_rdata", r, 32'hDEADBEEF);

    access(1'b0, 1'b0, 32'h102, 32'h0, 0, h, r, sc);
    $display("lbu 0x102: hit=%0b rdata=%h", h, r);
    check("lbu_hit", 32'(h), 32'd1);
    check("lbu_rdata", r, 32'h000000AD);
    check("lbu_stall_cycles", 32'(sc), 32'd0);

    access(1'b1, 1'b0, 32'h101, 32'h0000005A, 1, h, r, sc);
    $display("sb  0x101 <= 5a: hit=%0b stall_cycles=%0d", h, sc);
    check("sb_stall_cycles", 32'(sc), 32'd3);

    access(1'b0, 1'b1, 32'h100, 32'h0, 0, h, r, sc);
    $display("lw  0x100 after sb: hit=%0b rdata=%h", h, r);
    check("lw_after_sb", r, 32'hDEAD5AEF);

    idle(1'b1);

    access(1'b1, 1'b1, 32'h200, 32'h12345678, 0, h, r, sc);
    $display("sw  0x200 <= 12345678: hit=%0b", h);
    access(1'b0, 1'b1, 32'h200, 32'h0, 2, h, r, sc);
    $display("lw  0x200 after sw miss: hit=%0b rdata=%h", h, r);
    check("no_allocate_miss", 32'(h), 32'd0);
    check("no_allocate_rdata", r, 32'h12345678);

    // Set 3: tags A, B, C; a hit on A between the B and C fills makes B the victim.
    access(1'b0, 1'b1, 32'h00C, 32'h0, 1, h, r, sc);
    access(1'b0, 1'b1, 32'h02C, 32'h0, 0, h, r, sc);
    access(1'b0, 1'b1, 32'h00C, 32'h0, 0, h, r, sc);
    check("evict_a_hit_before_c", 32'(h), 32'd1);
    access(1'b0, 1'b1, 32'h04C, 32'h0, 2, h, r, sc);
    access(1'b0, 1'b1, 32'h00C, 32'h0, 0, h, r, sc);
    $display("lw  A after C fill: hit=%0b", h);
    check("evict_a_still_hits", 32'(h), 32'd1);
    access(1'b0, 1'b1, 32'h02C, 32'h0, 0, h, r, sc);
    $display("lw  B after C fill: hit=%0b", h);
    check("evict_b_misses", 32'(h), 32'd0);

    // Random mix over two sets and four tags per set.
    for (int i = 0; i < 200; i++) begin
      logic rw, rs;
      a  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h20 + 32'($urandom_range(0, 1)) * 32'h4
         + 32'($urandom_range(0, 3));
      rw = ($urandom_range(0, 2) == 0);
      rs = 1'($urandom_range(0, 1));
      access(rw, rs, a, $urandom, int'($urandom_range(0, 3)), h, r, sc);
      $display("rnd %0d: we=%0b size=%0b addr=%h hit=%0b rdata=%h", i, rw, rs, a, h, r);
      if ($urandom_range(0, 7) == 0) idle(1'($urandom_range(0, 1)));
    end

    // Reset while a miss is outstanding.
    @(negedge clk);
    req_valid = 1'b1; we = 1'b0; size = 1'b1; addr = 32'h7F0; mem_ack = 1'b0;
    #1;
    check("mid_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check("mid_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    $display("rst mid-miss: mem_req=%0b stall=%0b", mem_req, stall);
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_hit", 32'(hit), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    m_clear();
    access(1'b0, 1'b1, 32'h100, 32'h0, 1, h, r, sc);
    $display("lw  0x100 after reset: hit=%0b", h);
    check("after_rst_miss_0x100", 32'(h), 32'd0);
    access(1'b0, 1'b1, 32'h00C, 32'h0, 0, h, r, sc);
    $display("lw  0x00C after reset: hit=%0b", h);
    check("after_rst_miss_0x00c", 32'(h), 32'd0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
